// File: rtl/mem_pkg.sv
// Shared definitions for the SRAM memory-access stage: FSM encoding, half-select
// constants and the default address window.
package mem_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } memState_e;

    localparam logic        HALF_LO           = 1'b0;
    localparam logic        HALF_HI           = 1'b1;
    localparam int          CNT_W             = 4;
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;
endpackage

// File: rtl/sram_wait_counter.sv
// Loadable down-counter that paces each 16-bit SRAM half access.
module sram_wait_counter
    import mem_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] loadVal,
    output logic [W-1:0] value,
    output logic         zero
);
    // Saturates at zero so the idle count stays put between accesses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            value <= '0;
        else if (load)
            value <= loadVal;
        else if (value != '0)
            value <= value - 1'b1;
    end

    assign zero = (value == '0);
endmodule

// File: rtl/mem_stage_sram.sv
// MEM stage: splits each 32-bit load/store into two wait-stated 16-bit SRAM
// accesses and freezes the pipeline (ready low) until the word is complete.
module mem_stage_sram
    import mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int          WAIT_CYCLES = 4,
    parameter int          SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_r_en,
    input  logic               mem_w_en,
    input  logic [31:0]        alu_res,
    input  logic [31:0]        st_val,
    output logic               ready,
    output logic [31:0]        rdata,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_dq_oe,
    output logic               sram_we_n
);
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    memState_e          state, nextState;
    logic               request, cntLoad, cntZero, isWrite, busy;
    logic [CNT_W-1:0]   cntValue;
    logic [SRAM_AW-2:0] wordIdx;

    assign request = mem_r_en | mem_w_en;
    // Out-of-window addresses simply wrap through the truncation.
    assign wordIdx = (SRAM_AW-1)'((alu_res - BASE_ADDR) >> 2);

    sram_wait_counter #(.W(CNT_W)) waitCnt (
        .clk    (clk),
        .rst    (rst),
        .load   (cntLoad),
        .loadVal(WAIT_LOAD),
        .value  (cntValue),
        .zero   (cntZero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= nextState;
    end

    always_comb begin
        nextState = state;
        cntLoad   = 1'b0;
        case (state)
            IDLE: if (request) begin
                nextState = LOW;
                cntLoad   = 1'b1;
            end
            LOW: if (cntZero) begin
                nextState = HIGH;
                cntLoad   = 1'b1;
            end
            HIGH: if (cntZero) nextState = DONE;
            DONE: nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Address/data for each half are set up one edge ahead so they are stable
    // for the whole half; read data is captured on the final cycle of a half.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            isWrite     <= 1'b0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            rdata       <= '0;
        end else begin
            case (state)
                IDLE: if (request) begin
                    isWrite   <= mem_w_en;
                    sram_addr <= {wordIdx, HALF_LO};
                    if (mem_w_en) sram_dq_out <= st_val[15:0];
                end
                LOW: if (cntZero) begin
                    sram_addr <= {wordIdx, HALF_HI};
                    if (isWrite) sram_dq_out <= st_val[31:16];
                    else         rdata[15:0] <= sram_dq_in;
                end
                HIGH: if (cntZero && !isWrite) rdata[31:16] <= sram_dq_in;
                default: ;
            endcase
        end
    end

    assign busy       = (state == LOW) || (state == HIGH);
    assign sram_dq_oe = busy & isWrite;
    // Strobe released on the last cycle of each half for address/data hold.
    assign sram_we_n  = ~(busy & isWrite & (cntValue != '0));
    assign ready      = ((state == IDLE) & ~request) | (state == DONE);
endmodule

// File: tb/tb_mem_stage_sram.sv
// Bench for mem_stage_sram: two instances (W=4 and W=2) with SRAM models,
// checked against an op-level reference of address, strobe and data timing.
module tb_mem_stage_sram;
    localparam int AW = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        rEn, wEn, selA;
    logic [31:0] aluRes, stVal;

    logic          readyA, readyB, oeA, oeB, weA, weB;
    logic [31:0]   rdataA, rdataB;
    logic [AW-1:0] addrA, addrB;
    logic [15:0]   doutA, doutB, dinA, dinB;

    logic [15:0] memA [0:(1<<AW)-1];
    logic [15:0] memB [0:(1<<AW)-1];
    logic [15:0] refMem [0:1][0:(1<<AW)-1];
    logic [AW-1:0] lastAddr [0:1];
    logic [31:0]   lastRdata [0:1];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_stage_sram #(.BASE_ADDR(32'd1024), .WAIT_CYCLES(4), .SRAM_AW(AW)) dutA (
        .clk(clk), .rst(rst), .mem_r_en(rEn & selA), .mem_w_en(wEn & selA),
        .alu_res(aluRes), .st_val(stVal), .ready(readyA), .rdata(rdataA),
        .sram_addr(addrA), .sram_dq_out(doutA), .sram_dq_in(dinA),
        .sram_dq_oe(oeA), .sram_we_n(weA)
    );

    mem_stage_sram #(.BASE_ADDR(32'd1024), .WAIT_CYCLES(2), .SRAM_AW(AW)) dutB (
        .clk(clk), .rst(rst), .mem_r_en(rEn & ~selA), .mem_w_en(wEn & ~selA),
        .alu_res(aluRes), .st_val(stVal), .ready(readyB), .rdata(rdataB),
        .sram_addr(addrB), .sram_dq_out(doutB), .sram_dq_in(dinB),
        .sram_dq_oe(oeB), .sram_we_n(weB)
    );

    function automatic logic [15:0] pat(input int a, input int salt);
        return 16'(a * 40503 + salt);
    endfunction

    assign dinA = memA[addrA];
    assign dinB = memB[addrB];

    initial begin
        for (int i = 0; i < (1<<AW); i++) memA[i] = pat(i, 0);
        forever begin
            @(posedge clk);
            if (!weA) memA[addrA] <= doutA;
        end
    end

    initial begin
        for (int i = 0; i < (1<<AW); i++) memB[i] = pat(i, 7);
        forever begin
            @(posedge clk);
            if (!weB) memB[addrB] <= doutB;
        end
    end

    logic          oReady, oOe, oWe;
    logic [AW-1:0] oAddr;
    logic [15:0]   oDout;
    logic [31:0]   oRdata;
    assign oReady = selA ? readyA : readyB;
    assign oOe    = selA ? oeA    : oeB;
    assign oWe    = selA ? weA    : weB;
    assign oAddr  = selA ? addrA  : addrB;
    assign oDout  = selA ? doutA  : doutB;
    assign oRdata = selA ? rdataA : rdataB;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        int idx;
        rEn = 1'b0;
        wEn = 1'b0;
        repeat (n) begin
            @(negedge clk);
            idx = selA ? 0 : 1;
            chk("idle_ready", 32'(oReady), 32'd1);
            chk("idle_oe",    32'(oOe),    32'd0);
            chk("idle_we_n",  32'(oWe),    32'd1);
            chk("idle_addr",  32'(oAddr),  32'(lastAddr[idx]));
            chk("idle_rdata", oRdata,      lastRdata[idx]);
            @(posedge clk); #1;
        end
    endtask

    // One complete transaction, checked cycle by cycle from the request cycle
    // through DONE; returns the number of frozen cycles seen.
    task automatic runOp(input bit useA, input bit r, input bit w,
                         input logic [31:0] alu, input logic [31:0] st, output int stall);
        int wc, idx, last;
        logic [31:0] off, rdExp;
        logic [AW-2:0] word;
        logic [AW-1:0] lo, hi;
        bit busyK, loK;
        wc   = useA ? 4 : 2;
        idx  = useA ? 0 : 1;
        last = 2 * wc + 1;
        off  = alu - 32'd1024;
        word = off[AW:2];
        lo   = {word, 1'b0};
        hi   = {word, 1'b1};
        rdExp = {refMem[idx][hi], refMem[idx][lo]};
        selA = useA; rEn = r; wEn = w; aluRes = alu; stVal = st;
        stall = 0;
        for (int k = 0; k <= last; k++) begin
            @(negedge clk);
            if (!oReady) stall++;
            busyK = (k >= 1) && (k <= 2 * wc);
            loK   = (k <= wc);
            chk("ready", 32'(oReady), 32'(k == last));
            chk("dq_oe", 32'(oOe), 32'(busyK && w));
            chk("we_n",  32'(oWe), 32'(!(busyK && w && k != wc && k != 2 * wc)));
            chk("addr",  32'(oAddr), 32'(k == 0 ? lastAddr[idx] : (loK ? lo : hi)));
            if (busyK && w)
                chk("dq_out", 32'(oDout), 32'(loK ? st[15:0] : st[31:16]));
            if (w || k == 0)
                chk("rdata_hold", oRdata, lastRdata[idx]);
            else if (k == last)
                chk("rdata_load", oRdata, rdExp);
            if (k < last) begin
                @(posedge clk); #1;
            end
        end
        lastAddr[idx] = hi;
        if (w) begin
            refMem[idx][lo] = st[15:0];
            refMem[idx][hi] = st[31:16];
        end else begin
            lastRdata[idx] = rdExp;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int s1, s2, ua, kind;
        logic [31:0] alu, st;
        for (int i = 0; i < (1<<AW); i++) begin
            refMem[0][i] = pat(i, 0);
            refMem[1][i] = pat(i, 7);
        end
        for (int i = 0; i < 2; i++) begin
            lastAddr[i]  = '0;
            lastRdata[i] = '0;
        end
        rst = 1'b1; rEn = 1'b0; wEn = 1'b0; selA = 1'b1;
        aluRes = '0; stVal = '0;

        @(negedge clk);
        chk("rst_ready", 32'(oReady), 32'd1);
        chk("rst_rdata", oRdata, 32'd0);
        chk("rst_addr",  32'(oAddr), 32'd0);
        chk("rst_dout",  32'(oDout), 32'd0);
        chk("rst_we_n",  32'(oWe), 32'd1);
        chk("rst_oe",    32'(oOe), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        idle(10);

        runOp(1'b1, 1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, s1);
        chk("store_stall", 32'(s1), 32'd9);
        runOp(1'b1, 1'b1, 1'b0, 32'd1032, 32'h0, s1);
        idle(1);
        chk("load_word", oRdata, 32'hDEADBEEF);

        runOp(1'b1, 1'b1, 1'b0, 32'd1032, 32'h0, s1);
        runOp(1'b1, 1'b0, 1'b1, 32'd1100, 32'hCAFEF00D, s2);
        chk("b2b_stall", 32'(s1 + s2), 32'd18);
        idle(2);

        runOp(1'b0, 1'b1, 1'b1, 32'd1040, 32'hA5A55A5A, s1);
        chk("both_stall", 32'(s1), 32'd5);
        runOp(1'b0, 1'b1, 1'b0, 32'd1040, 32'h0, s1);
        idle(1);

        for (int n = 0; n < 40; n++) begin
            ua   = $urandom_range(0, 1);
            kind = $urandom_range(0, 3);
            alu  = 32'd960 + 32'($urandom_range(0, 4095));
            st   = $urandom;
            runOp(ua[0], kind != 1, kind == 1 || kind == 2, alu, st, s1);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
        end

        // Reset during the high half of a store on the W=4 instance.
        selA = 1'b1; rEn = 1'b0; wEn = 1'b1;
        aluRes = 32'd1224; stVal = 32'h12345678;
        repeat (6) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_we_n",  32'(oWe), 32'd1);
        chk("abort_oe",    32'(oOe), 32'd0);
        chk("abort_addr",  32'(oAddr), 32'd0);
        chk("abort_rdata", oRdata, 32'd0);
        rEn = 1'b0; wEn = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_ready", 32'(oReady), 32'd1);
        refMem[0][100] = 16'h5678;
        refMem[0][101] = 16'h1234;
        for (int i = 0; i < 2; i++) begin
            lastAddr[i]  = '0;
            lastRdata[i] = '0;
        end
        @(posedge clk); #1;
        idle(2);
        runOp(1'b1, 1'b1, 1'b0, 32'd1224, 32'h0, s1);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
